// File: rtl/mc_controller_hs.sv
// Multicycle control FSM for the 16-bit CR16-style CPU with a req/ready memory
// handshake, a run gate at instruction fetch and a sticky bus-timeout fault.
module mc_controller_hs #(
  parameter int OPW     = 4,
  parameter int PSRL    = 5,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  OP_CODE,
  input  logic [OPW-1:0]  OP_EXT,
  input  logic [OPW-1:0]  branch_cond,
  input  logic [PSRL-1:0] PSR_OUT,
  input  logic            mem_ready,
  input  logic            run,
  output logic            mem_req,
  output logic            MEM_WR_S,
  output logic            MEM_S,
  output logic            PC_S,
  output logic [1:0]      WD_S,
  output logic [1:0]      ALUA_S,
  output logic [1:0]      ALUB_S,
  output logic            SE_SIGN,
  output logic            PC_EN,
  output logic            INSTR_EN,
  output logic            ALU_OUT_EN,
  output logic            MEM_REG_EN,
  output logic            PSR_EN,
  output logic            REG_WR,
  output logic            fault,
  output logic [2:0]      state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB     = 4'd3,
    S_MEMRD  = 4'd4,
    S_LDWB   = 4'd5,
    S_MEMWR  = 4'd6,
    S_BRANCH = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_MEM   = OPW'(4'b0100);
  localparam logic [OPW-1:0] OP_ADDI  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_MULI  = OPW'(4'b1001);
  localparam logic [OPW-1:0] OP_CMPI  = OPW'(4'b1011);
  localparam logic [OPW-1:0] OP_BCOND = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_MOVI  = OPW'(4'b1101);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(4'b1111);
  localparam logic [OPW-1:0] EX_LOAD  = OPW'(4'b0000);
  localparam logic [OPW-1:0] EX_STOR  = OPW'(4'b0100);
  localparam logic [OPW-1:0] EX_JAL   = OPW'(4'b1000);
  localparam logic [OPW-1:0] EX_JCOND = OPW'(4'b1100);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          r_state;
  state_t          w_next;
  logic            r_pend;
  logic            r_fault;
  logic [TO_W-1:0] r_cnt;
  logic            w_take;
  logic            w_hit;

  // PSR bit map is {N,Z,F,L,C} with C at bit 0.
  function automatic logic eval_cond(input logic [OPW-1:0] c, input logic [PSRL-1:0] p);
    logic n, z, f, l, cy;
    n  = p[4];
    z  = p[3];
    f  = p[2];
    l  = p[1];
    cy = p[0];
    case (4'(c))
      4'b0000: eval_cond = z;
      4'b0001: eval_cond = !z;
      4'b0010: eval_cond = cy;
      4'b0011: eval_cond = !cy;
      4'b0100: eval_cond = l;
      4'b0101: eval_cond = !l;
      4'b0110: eval_cond = n;
      4'b0111: eval_cond = !n;
      4'b1000: eval_cond = f;
      4'b1001: eval_cond = !f;
      4'b1010: eval_cond = !l && !z;
      4'b1011: eval_cond = l || z;
      4'b1100: eval_cond = !n && !z;
      4'b1101: eval_cond = n || z;
      4'b1110: eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pend  <= 1'b0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= (r_state == S_FETCH) && (w_next == S_FETCH) && mem_req;
      r_fault <= r_fault || (w_next == S_FAULT);
      r_cnt   <= (mem_req && !mem_ready) ? r_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next     = r_state;
    mem_req    = 1'b0;
    MEM_WR_S   = 1'b0;
    MEM_S      = 1'b0;
    PC_S       = 1'b0;
    WD_S       = 2'b00;
    ALUA_S     = 2'b00;
    ALUB_S     = 2'b00;
    SE_SIGN    = 1'b0;
    PC_EN      = 1'b0;
    INSTR_EN   = 1'b0;
    ALU_OUT_EN = 1'b0;
    MEM_REG_EN = 1'b0;
    PSR_EN     = 1'b0;
    REG_WR     = 1'b0;
    w_take     = eval_cond(branch_cond, PSR_OUT);
    case (r_state)
      S_FETCH: begin
        // A pending request keeps going even if run drops mid-handshake.
        if (run || r_pend) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            INSTR_EN = 1'b1;
            PC_EN    = 1'b1;
            ALUA_S   = 2'b01;
            ALUB_S   = 2'b10;
            w_next   = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (OP_CODE == OP_RTYPE) begin
          w_next = S_EXEC;
        end else if (OP_CODE == OP_MEM) begin
          if (OP_EXT == EX_LOAD)                            w_next = S_MEMRD;
          else if (OP_EXT == EX_STOR)                       w_next = S_MEMWR;
          else if ((OP_EXT == EX_JCOND) || (OP_EXT == EX_JAL)) w_next = S_BRANCH;
          else                                              w_next = S_FETCH;
        end else if (OP_CODE == OP_BCOND) begin
          w_next = S_BRANCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALU_OUT_EN = 1'b1;
        PSR_EN     = (OP_CODE != OP_LUI);
        ALUB_S     = (OP_CODE == OP_RTYPE) ? 2'b00 : 2'b01;
        ALUA_S     = (OP_CODE == OP_MOVI) ? 2'b10 : 2'b00;
        SE_SIGN    = (OP_CODE == OP_ADDI) || (OP_CODE == OP_MULI) || (OP_CODE == OP_CMPI);
        w_next     = S_WB;
      end
      S_WB: begin
        REG_WR = 1'b1;
        WD_S   = (OP_CODE == OP_LUI) ? 2'b11 : 2'b00;
        w_next = S_FETCH;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        MEM_S   = 1'b1;
        if (mem_ready) begin
          MEM_REG_EN = 1'b1;
          w_next     = S_LDWB;
        end
      end
      S_LDWB: begin
        REG_WR = 1'b1;
        WD_S   = 2'b01;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MEM_S    = 1'b1;
        MEM_WR_S = 1'b1;
        if (mem_ready) w_next = S_FETCH;
      end
      S_BRANCH: begin
        if (OP_CODE == OP_BCOND) begin
          if (w_take) begin
            PC_EN   = 1'b1;
            ALUA_S  = 2'b01;
            ALUB_S  = 2'b01;
            SE_SIGN = 1'b1;
          end
        end else if (OP_EXT == EX_JAL) begin
          REG_WR = 1'b1;
          WD_S   = 2'b10;
          PC_EN  = 1'b1;
          PC_S   = 1'b1;
        end else if (w_take) begin
          PC_EN = 1'b1;
          PC_S  = 1'b1;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_FAULT;
    endcase
    // A ready arriving on the limit cycle wins over the timeout.
    w_hit = (TIMEOUT != 0) && mem_req && !mem_ready && (r_cnt == TO_LIM);
    if (w_hit) w_next = S_FAULT;
    fault     = r_fault;
    state_dbg = (r_state == S_FAULT) ? 3'd7 : r_state[2:0];
    if (reset) begin
      mem_req    = 1'b0;
      MEM_WR_S   = 1'b0;
      MEM_S      = 1'b0;
      PC_S       = 1'b0;
      WD_S       = 2'b00;
      ALUA_S     = 2'b00;
      ALUB_S     = 2'b00;
      SE_SIGN    = 1'b0;
      PC_EN      = 1'b0;
      INSTR_EN   = 1'b0;
      ALU_OUT_EN = 1'b0;
      MEM_REG_EN = 1'b0;
      PSR_EN     = 1'b0;
      REG_WR     = 1'b0;
      fault      = 1'b0;
      state_dbg  = 3'd0;
    end
  end

endmodule

// File: tb/tb_mc_controller_hs.sv
// Scoreboard bench for mc_controller_hs: each driven cycle queues its expected
// output vector, and the negedge monitor pops and compares it.
module tb_mc_controller_hs;

  logic       clk = 1'b0;
  logic       reset, run, rdy;
  logic [3:0] op, ext, cnd;
  logic [4:0] psr;
  logic       mem_req, wr_s, mem_s, pc_s, se, pc_en, ir_en, aout_en, mreg_en, psr_en, reg_wr, flt;
  logic [1:0] wd_s, alua_s, alub_s;
  logic [2:0] st_dbg;

  typedef struct {
    string       tag;
    logic [21:0] v;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  mc_controller_hs #(.OPW(4), .PSRL(5), .TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .OP_CODE(op), .OP_EXT(ext), .branch_cond(cnd),
    .PSR_OUT(psr), .mem_ready(rdy), .run(run), .mem_req(mem_req), .MEM_WR_S(wr_s),
    .MEM_S(mem_s), .PC_S(pc_s), .WD_S(wd_s), .ALUA_S(alua_s), .ALUB_S(alub_s),
    .SE_SIGN(se), .PC_EN(pc_en), .INSTR_EN(ir_en), .ALU_OUT_EN(aout_en),
    .MEM_REG_EN(mreg_en), .PSR_EN(psr_en), .REG_WR(reg_wr), .fault(flt),
    .state_dbg(st_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [21:0] ex(input logic [2:0] st, input logic req, input logic wr,
                                     input logic ms, input logic pcs, input logic [1:0] wd,
                                     input logic [1:0] aa, input logic [1:0] ab, input logic sgn,
                                     input logic pcen, input logic ien, input logic aen,
                                     input logic mren, input logic pen, input logic rw,
                                     input logic fl);
    return {req, wr, ms, pcs, wd, aa, ab, sgn, pcen, ien, aen, mren, pen, rw, fl, st};
  endfunction

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_val(e.tag, 32'({mem_req, wr_s, mem_s, pc_s, wd_s, alua_s, alub_s, se, pc_en, ir_en,
                            aout_en, mreg_en, psr_en, reg_wr, flt, st_dbg}), 32'(e.v));
    end
  end

  task automatic cyc(input string tag, input logic [21:0] v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  logic [21:0] E_FW, E_FR, E_DEC, E_EXR, E_WB, E_MW, E_BNT, E_BT, E_FLT;

  initial begin
    E_FW  = ex(3'd0, 1,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,0);
    E_FR  = ex(3'd0, 1,0,0,0, 2'd0,2'd1,2'd2, 0,1,1,0,0,0,0,0);
    E_DEC = ex(3'd1, 0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,0);
    E_EXR = ex(3'd2, 0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,1,0,1,0,0);
    E_WB  = ex(3'd3, 0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,1,0);
    E_MW  = ex(3'd6, 1,1,1,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,0);
    E_BNT = ex(3'd7, 0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,0);
    E_BT  = ex(3'd7, 0,0,0,0, 2'd0,2'd1,2'd1, 1,1,0,0,0,0,0,0);
    E_FLT = ex(3'd7, 0,0,0,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,1);

    reset = 1'b1; run = 1'b1; rdy = 1'b1;
    op = 4'b0000; ext = 4'b0101; cnd = 4'b0000; psr = 5'b00000;
    @(posedge clk);
    #1;
    cyc("rst", '0);
    reset = 1'b0;
    cyc("add_f", E_FR); cyc("add_d", E_DEC); cyc("add_e", E_EXR); cyc("add_w", E_WB);

    rdy = 1'b0;
    cyc("fw1", E_FW); cyc("fw2", E_FW); cyc("fw3", E_FW);
    rdy = 1'b1; op = 4'b0100; ext = 4'b0100;
    cyc("fw_rdy", E_FR); cyc("st_d", E_DEC);
    rdy = 1'b0;
    cyc("st_w1", E_MW); cyc("st_w2", E_MW);
    rdy = 1'b1;
    cyc("st_w3", E_MW);

    op = 4'b1100; ext = 4'b0000; cnd = 4'b0000; psr = 5'b01000;
    cyc("beq_f", E_FR); cyc("beq_d", E_DEC); cyc("beq_t", E_BT);
    psr = 5'b00000;
    cyc("beq2_f", E_FR); cyc("beq2_d", E_DEC); cyc("beq_nt", E_BNT);
    cnd = 4'b1100;
    cyc("blt_f", E_FR); cyc("blt_d", E_DEC); cyc("blt_t", E_BT);

    op = 4'b0100; ext = 4'b1000; cnd = 4'b1111;
    cyc("jal_f", E_FR); cyc("jal_d", E_DEC);
    cyc("jal_b", ex(3'd7, 0,0,0,1, 2'd2,2'd0,2'd0, 0,1,0,0,0,0,1,0));
    ext = 4'b1100; cnd = 4'b1110;
    cyc("juc_f", E_FR); cyc("juc_d", E_DEC);
    cyc("juc_b", ex(3'd7, 0,0,0,1, 2'd0,2'd0,2'd0, 0,1,0,0,0,0,0,0));
    cnd = 4'b1111;
    cyc("jnv_f", E_FR); cyc("jnv_d", E_DEC); cyc("jnv_b", E_BNT);

    op = 4'b1111; ext = 4'b0000;
    cyc("lui_f", E_FR); cyc("lui_d", E_DEC);
    cyc("lui_e", ex(3'd2, 0,0,0,0, 2'd0,2'd0,2'd1, 0,0,0,1,0,0,0,0));
    cyc("lui_w", ex(3'd3, 0,0,0,0, 2'd3,2'd0,2'd0, 0,0,0,0,0,0,1,0));
    op = 4'b1101;
    cyc("movi_f", E_FR); cyc("movi_d", E_DEC);
    cyc("movi_e", ex(3'd2, 0,0,0,0, 2'd0,2'd2,2'd1, 0,0,0,1,0,1,0,0));
    cyc("movi_w", E_WB);
    op = 4'b0101;
    cyc("addi_f", E_FR); cyc("addi_d", E_DEC);
    cyc("addi_e", ex(3'd2, 0,0,0,0, 2'd0,2'd0,2'd1, 1,0,0,1,0,1,0,0));
    cyc("addi_w", E_WB);

    op = 4'b0100; ext = 4'b0000;
    cyc("ld_f", E_FR); cyc("ld_d", E_DEC);
    rdy = 1'b0;
    cyc("ld_w", ex(3'd4, 1,0,1,0, 2'd0,2'd0,2'd0, 0,0,0,0,0,0,0,0));
    rdy = 1'b1;
    cyc("ld_r", ex(3'd4, 1,0,1,0, 2'd0,2'd0,2'd0, 0,0,0,0,1,0,0,0));
    cyc("ld_wb", ex(3'd5, 0,0,0,0, 2'd1,2'd0,2'd0, 0,0,0,0,0,0,1,0));
    ext = 4'b0001;
    cyc("nop_f", E_FR); cyc("nop_d", E_DEC); cyc("nop_back", E_FR);

    reset = 1'b1;
    cyc("rst2", '0);
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 5; i++) cyc("run_idle", '0);
    run = 1'b1; rdy = 1'b0;
    cyc("run_req", E_FW);
    run = 1'b0;
    cyc("run_hold", E_FW);
    rdy = 1'b1;
    cyc("run_rdy", E_FR);
    cyc("run_d", E_DEC);
    cyc("run_stall", '0);

    run = 1'b1; rdy = 1'b0;
    cyc("to1", E_FW); cyc("to2", E_FW); cyc("to3", E_FW); cyc("to4", E_FW);
    cyc("flt1", E_FLT);
    rdy = 1'b1;
    cyc("flt2", E_FLT); cyc("flt3", E_FLT);
    reset = 1'b1;
    cyc("to_rst", '0);
    reset = 1'b0; run = 1'b0;
    cyc("to_clr", '0);
    run = 1'b1;
    cyc("to_rec", E_FR);

    check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
